// File: rtl/mult_result_mem.sv
`default_nettype none
// ============================================================================
// mult_result_mem : result store for the multiplier, with per-entry valid bits,
//                   write-first reads, fill counting and sticky error flags.
// Revision 1.0
// ============================================================================
module mult_result_mem #(
    parameter int LOGDEPTH = 6,
    parameter int WIDTH    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                EN_writeMem,
    input  logic [LOGDEPTH-1:0] writeMem_addr,
    input  logic [WIDTH-1:0]    writeMem_val,
    input  logic                EN_readMem,
    input  logic [LOGDEPTH-1:0] readMem_addr,
    output logic [WIDTH-1:0]    readMem_val,
    output logic                readMem_valid,
    input  logic                clr_valid,
    output logic [LOGDEPTH:0]   wr_count,
    output logic                mem_full,
    output logic                err_unwritten,
    output logic                err_overwrite
);

    localparam int               DEPTH   = 1 << LOGDEPTH;
    localparam logic [LOGDEPTH:0] c_one   = {{LOGDEPTH{1'b0}}, 1'b1};
    localparam logic [LOGDEPTH:0] c_depth = {1'b1, {LOGDEPTH{1'b0}}};

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [DEPTH-1:0]    r_valid;
    logic [WIDTH-1:0]    r_rd_val;
    logic                r_rd_valid;
    logic [LOGDEPTH:0]   r_wr_count;
    logic                r_err_unw;
    logic                r_err_ovw;

    logic                w_collide;
    logic                w_rd_hit;
    logic [WIDTH-1:0]    w_rd_data;
    logic                w_wr_new;

    // Reads see pre-clear valid bits; a same-address write forwards its data.
    always_comb begin
        w_collide = EN_writeMem && (writeMem_addr == readMem_addr);
        w_rd_hit  = w_collide || r_valid[readMem_addr];
        if (w_collide)
            w_rd_data = writeMem_val;
        else if (r_valid[readMem_addr])
            w_rd_data = r_mem[readMem_addr];
        else
            w_rd_data = '0;
        w_wr_new  = EN_writeMem && (clr_valid || !r_valid[writeMem_addr]);
    end

    always_ff @(posedge clk) begin
        if (rst_n && EN_writeMem)
            r_mem[writeMem_addr] <= writeMem_val;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid    <= '0;
            r_rd_val   <= '0;
            r_rd_valid <= 1'b0;
            r_wr_count <= '0;
            r_err_unw  <= 1'b0;
            r_err_ovw  <= 1'b0;
        end else begin
            r_rd_valid <= EN_readMem;
            if (EN_readMem)
                r_rd_val <= w_rd_data;

            // Clear first, then the write lands on the freshly cleared map.
            if (clr_valid)
                r_valid <= '0;
            if (EN_writeMem)
                r_valid[writeMem_addr] <= 1'b1;

            if (clr_valid)
                r_wr_count <= EN_writeMem ? c_one : '0;
            else if (w_wr_new)
                r_wr_count <= r_wr_count + c_one;

            if (clr_valid)
                r_err_ovw <= 1'b0;
            else if (EN_writeMem && r_valid[writeMem_addr])
                r_err_ovw <= 1'b1;

            if (clr_valid)
                r_err_unw <= 1'b0;
            else if (EN_readMem && !w_rd_hit)
                r_err_unw <= 1'b1;
        end
    end

    assign readMem_val   = r_rd_val;
    assign readMem_valid = r_rd_valid;
    assign wr_count      = r_wr_count;
    assign mem_full      = (r_wr_count == c_depth);
    assign err_unwritten = r_err_unw;
    assign err_overwrite = r_err_ovw;

endmodule
`default_nettype wire

// File: tb/tb_mult_result_mem.sv
`default_nettype none
// Directed bench for mult_result_mem: behavioural model compared every cycle
// plus hand-computed literal checks.
module tb_mult_result_mem;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        EN_writeMem = 1'b0;
    logic [5:0]  writeMem_addr = '0;
    logic [31:0] writeMem_val = '0;
    logic        EN_readMem = 1'b0;
    logic [5:0]  readMem_addr = '0;
    logic [31:0] readMem_val;
    logic        readMem_valid;
    logic        clr_valid = 1'b0;
    logic [6:0]  wr_count;
    logic        mem_full;
    logic        err_unwritten;
    logic        err_overwrite;

    int nvec = 0;
    int nmis = 0;
    bit chk_en = 1'b0;

    mult_result_mem #(.LOGDEPTH(6), .WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .EN_writeMem(EN_writeMem), .writeMem_addr(writeMem_addr), .writeMem_val(writeMem_val),
        .EN_readMem(EN_readMem), .readMem_addr(readMem_addr),
        .readMem_val(readMem_val), .readMem_valid(readMem_valid),
        .clr_valid(clr_valid), .wr_count(wr_count), .mem_full(mem_full),
        .err_unwritten(err_unwritten), .err_overwrite(err_overwrite)
    );

    always #5 clk = ~clk;

    // Behavioural model: storage, valid map, expected outputs.
    logic [31:0] m_mem [64];
    logic [63:0] m_valid = '0;
    logic [31:0] m_rval = '0;
    logic        m_rvalid = 1'b0;
    logic        m_eu = 1'b0;
    logic        m_eo = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid = '0; m_rval = '0; m_rvalid = 1'b0; m_eu = 1'b0; m_eo = 1'b0;
        end else begin
            if (EN_readMem) begin
                if (EN_writeMem && writeMem_addr == readMem_addr)
                    m_rval = writeMem_val;
                else if (m_valid[readMem_addr])
                    m_rval = m_mem[readMem_addr];
                else begin
                    m_rval = '0;
                    m_eu = 1'b1;
                end
            end
            m_rvalid = EN_readMem;
            if (clr_valid) begin
                m_valid = '0; m_eu = 1'b0; m_eo = 1'b0;
            end
            if (EN_writeMem) begin
                if (m_valid[writeMem_addr]) m_eo = 1'b1;
                m_valid[writeMem_addr] = 1'b1;
                m_mem[writeMem_addr] = writeMem_val;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_valid", 64'(readMem_valid), 64'(m_rvalid));
            check("m_val", 64'(readMem_val), 64'(m_rval));
            check("m_count", 64'(wr_count), 64'($countones(m_valid)));
            check("m_full", 64'(mem_full), 64'($countones(m_valid) == 64));
            check("m_err_unw", 64'(err_unwritten), 64'(m_eu));
            check("m_err_ovw", 64'(err_overwrite), 64'(m_eo));
        end
    end

    // One clock of stimulus; returns 2 time units after the rising edge.
    task automatic step(input bit rn, input bit we, input logic [5:0] wa, input logic [31:0] wd,
                        input bit re, input logic [5:0] ra, input bit clr);
        rst_n = rn; EN_writeMem = we; writeMem_addr = wa; writeMem_val = wd;
        EN_readMem = re; readMem_addr = ra; clr_valid = clr;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        chk_en = 1'b1;
        check("rst_valid", 64'(readMem_valid), 64'd0);
        check("rst_val", 64'(readMem_val), 64'd0);
        check("rst_count", 64'(wr_count), 64'd0);
        check("rst_flags", 64'({err_unwritten, err_overwrite, mem_full}), 64'd0);

        // Fill
        for (int i = 0; i < 64; i++) step(1, 1, 6'(i), 32'(i * 3), 0, 0, 0);
        check("fill_count", 64'(wr_count), 64'd64);
        check("fill_full", 64'(mem_full), 64'd1);
        check("fill_flags", 64'({err_unwritten, err_overwrite}), 64'd0);

        // Readback
        for (int i = 0; i < 64; i++) begin
            step(1, 0, 0, 0, 1, 6'(i), 0);
            if (i == 5) check("rb_addr5", 64'(readMem_val), 64'd15);
            if (i == 63) check("rb_addr63", 64'(readMem_val), 64'd189);
        end
        idle();

        // Clear + write
        step(1, 1, 7, 32'h1234_5677, 0, 0, 1);
        check("cw_count", 64'(wr_count), 64'd1);
        check("cw_full", 64'(mem_full), 64'd0);
        step(1, 0, 0, 0, 1, 7, 0);
        check("cw_rd7", 64'(readMem_val), 64'h1234_5677);
        step(1, 0, 0, 0, 1, 8, 0);
        check("cw_rd8", 64'(readMem_val), 64'd0);
        check("cw_unw", 64'(err_unwritten), 64'd1);
        idle();

        // Reset mid-readback (refill a few entries first)
        for (int i = 0; i < 8; i++) step(1, 1, 6'(i), 32'(100 + i), 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(i == 4 ? 1'b0 : 1'b1, 0, 0, 0, 1, 6'(i), 0);
            if (i == 4) begin
                check("mr_valid", 64'(readMem_valid), 64'd0);
                check("mr_val", 64'(readMem_val), 64'd0);
                check("mr_count", 64'(wr_count), 64'd0);
            end
            if (i == 6) check("mr_after", 64'(readMem_val), 64'd0);
        end
        step(1, 0, 0, 0, 0, 0, 1);

        // Collision on empty memory
        step(1, 1, 5, 32'hDEAD_BEEF, 1, 5, 0);
        check("col_val", 64'(readMem_val), 64'hDEAD_BEEF);
        check("col_unw", 64'(err_unwritten), 64'd0);
        step(1, 0, 0, 0, 0, 0, 1);

        // Error flags
        step(1, 0, 0, 0, 1, 9, 0);
        check("e_rd9", 64'(readMem_val), 64'd0);
        check("e_unw", 64'(err_unwritten), 64'd1);
        step(1, 1, 2, 32'h11, 0, 0, 0);
        step(1, 1, 2, 32'h22, 0, 0, 0);
        check("e_count", 64'(wr_count), 64'd1);
        check("e_ovw", 64'(err_overwrite), 64'd1);
        step(1, 0, 0, 0, 0, 0, 1);
        check("e_clr", 64'({err_unwritten, err_overwrite}), 64'd0);
        check("e_clr_cnt", 64'(wr_count), 64'd0);

        // Clear with read: read sees pre-clear valid bits
        step(1, 1, 3, 32'hCAFE, 0, 0, 0);
        step(1, 0, 0, 0, 1, 3, 1);
        check("cr_val", 64'(readMem_val), 64'hCAFE);
        check("cr_count", 64'(wr_count), 64'd0);
        idle();
        idle();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_result_mem.md
MULT_RESULT_MEM -- requirements
Module: mult_result_mem

Interface
REQ-001 SHALL have parameter LOGDEPTH, default 6: address width; DEPTH = 2**LOGDEPTH entries.
REQ-002 SHALL have parameter WIDTH, default 32: data word width.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port EN_writeMem  input  1  write strobe from the multiplier.
REQ-006 SHALL have port writeMem_addr  input  LOGDEPTH  write address.
REQ-007 SHALL have port writeMem_val  input  WIDTH  write data.
REQ-008 SHALL have port EN_readMem  input  1  read strobe from the multiplier.
REQ-009 SHALL have port readMem_addr  input  LOGDEPTH  read address.
REQ-010 SHALL have port readMem_val  output  WIDTH  registered read data.
REQ-011 SHALL have port readMem_valid  output  1  high for the cycle in which readMem_val is valid.
REQ-012 SHALL have port clr_valid  input  1  invalidates all entries, starting a new result block.
REQ-013 SHALL have port wr_count  output  LOGDEPTH+1  number of distinct valid entries.
REQ-014 SHALL have port mem_full  output  1  high when wr_count == DEPTH.
REQ-015 SHALL have port err_unwritten  output  1  sticky flag: a read hit an invalid entry.
REQ-016 SHALL have port err_overwrite  output  1  sticky flag: a write hit an already valid entry.

Function
REQ-017 SHALL hold DEPTH x WIDTH storage plus one valid bit per entry.
REQ-018 SHALL, on a cycle with EN_writeMem=1, store writeMem_val at writeMem_addr and set its valid bit at that edge.
REQ-019 SHALL increment wr_count by 1 on a write to an invalid entry; a write to a valid entry still stores data, leaves wr_count unchanged and sets err_overwrite.
REQ-020 SHALL, for EN_readMem=1 in cycle N, drive readMem_val and readMem_valid=1 in cycle N+1 (1-cycle latency); readMem_valid=0 otherwise.
REQ-021 SHALL, on a read of an invalid entry, return readMem_val=0, still assert readMem_valid, and set err_unwritten.
REQ-022 SHALL hold readMem_val at its last value when no read is issued.
REQ-023 SHALL, for a read and write to the same address in the same cycle, return the new write data (write-first) and treat the entry as valid (no err_unwritten).
REQ-024 SHALL accept one read and one write every cycle, back-to-back, with no stall.
REQ-025 SHALL, on clr_valid=1, clear all valid bits, wr_count and both error flags at that edge; storage contents are not cleared.
REQ-026 SHALL, when clr_valid and EN_writeMem coincide, apply the clear first then the write: the written entry is valid and wr_count=1.
REQ-027 SHALL, when clr_valid and EN_readMem coincide, evaluate the read against the pre-clear valid bits.
REQ-028 SHALL wrap no counter: wr_count saturates naturally at DEPTH because at most DEPTH entries can be valid.
REQ-029 SHALL combinationally derive mem_full from wr_count.
REQ-030 SHALL keep err_unwritten and err_overwrite set until clr_valid or reset.

Reset
REQ-031 SHALL, on rst_n=0 at a rising edge, clear all valid bits, wr_count=0, readMem_val=0, readMem_valid=0, err_unwritten=0, err_overwrite=0; mem_full=0 follows.
REQ-032 SHALL give reset priority over all other inputs; a read issued in the reset cycle produces no readMem_valid pulse.
REQ-033 SHALL not require storage contents to be reset; reads after reset return 0 via REQ-021.

Verification
REQ-034 SHALL cover fill: write addr 0..63 with value addr*3 on consecutive cycles -> wr_count=64, mem_full=1 the cycle after the last write, no error flags.
REQ-035 SHALL cover readback: after fill, read addr 0..63 back-to-back -> readMem_valid high for 64 consecutive cycles, readMem_val=addr*3, one cycle after each strobe.
REQ-036 SHALL cover collision: write 0xDEADBEEF to addr 5 and read addr 5 in the same cycle on an empty memory -> next cycle readMem_val=0xDEADBEEF, err_unwritten=0.
REQ-037 SHALL cover errors: read addr 9 when empty -> readMem_val=0, err_unwritten=1; write addr 2 twice -> wr_count=1, err_overwrite=1; clr_valid -> both flags 0, wr_count=0.
REQ-038 SHALL cover clear+write: after fill, clr_valid with a write to addr 7 -> wr_count=1, mem_full=0, read of addr 7 returns new data, read of addr 8 sets err_unwritten.
REQ-039 SHALL cover reset mid-operation: rst_n=0 during a readback stream -> next cycle readMem_valid=0, readMem_val=0, wr_count=0, and all reads return 0.
